// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   - Configurable width (XLEN), depth (NREGS), read ports (NRD) and write ports (NWR).
//   - x0 reads as zero, and writes to x0 are dropped.
//   - After reset, a sequential engine clears entries 1..NREGS-1, one per cycle.
//     This replaces a per-register reset preload.
//   - wr_conflict pulses for one cycle after two write ports hit the same non-zero register.
//   - Optional feature macro REGFILE_BYPASS_EN: when defined, a read port returns the
//     same-cycle write data of a matching write port.
//
// Handshake: ready is a level, not a per-transfer strobe.
//   - ready=0 (clearing): every wr_en is ignored and every rd_data port reads 0.
//   - ready=1: each write port with wr_en=1 and a non-zero wr_addr commits on the next rising edge.
//   - There is no back-pressure once ready is high.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                ready,
    output logic                wr_conflict,
    output logic                fsm_state
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   cnt, cnt_next;
    logic            conflict_d;
    logic [XLEN-1:0] mem [1:NREGS-1];

    assign ready     = (state == ST_RUN);
    assign fsm_state = state;

    // State and clear-counter registers; reset restarts clearing from entry 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_CLEAR;
            cnt         <= AW'(1);
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            wr_conflict <= conflict_d;
        end
    end

    // Next-state logic: walk cnt up to the last entry, then enter RUN.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_CLEAR: begin
                if (cnt == AW'(NREGS - 1)) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = AW'(1);
            end
        endcase
    end

    // Storage update: clear one entry per cycle in CLEAR, otherwise commit writes.
    // Later ports are applied last, so port 1 wins a collision.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                        mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // A collision only exists with two write ports. Writes to x0 never collide.
    generate
        if (NWR == 2) begin : g_conflict
            // Flag both ports writing the same non-zero register while running.
            always_comb begin
                conflict_d = (state == ST_RUN) && wr_en[0] && wr_en[1] &&
                             (wr_addr[0 +: AW] == wr_addr[AW +: AW]) &&
                             (wr_addr[0 +: AW] != '0);
            end
        end else begin : g_no_conflict
            assign conflict_d = 1'b0;
        end
    endgenerate

    // One combinational read mux per port.
    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd_word;
            assign ra = rd_addr[p*AW +: AW];

            // Read storage while running; x0 and the clearing phase read zero.
            always_comb begin
                rd_word = '0;
                if ((state == ST_RUN) && (ra != '0)) begin
                    rd_word = mem[ra];
`ifdef REGFILE_BYPASS_EN
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                            rd_word = wr_data[w*XLEN +: XLEN];
                        end
                    end
`endif
                end
            end

            assign rd_data[p*XLEN +: XLEN] = rd_word;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (NRD=2, NWR=2).
// The driver pushes expectations into a queue after each input change.
// A separate monitor drains the queue on the falling edge and compares against the DUT.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    localparam logic [1:0] K_RD0  = 2'd0;
    localparam logic [1:0] K_RD1  = 2'd1;
    localparam logic [1:0] K_RDY  = 2'd2;
    localparam logic [1:0] K_CONF = 2'd3;

    logic                clock;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                ready;
    logic                wr_conflict;
    logic                fsm_state;

    logic [XLEN-1:0] exp_q[$];
    logic [1:0]      kind_q[$];
    string           name_q[$];

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .AW   (AW),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ready      (ready),
        .wr_conflict(wr_conflict),
        .fsm_state  (fsm_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        wr_en   = {e1, e0};
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
        rd_addr = {r1, r0};
    endtask

    task automatic expect_val(input logic [1:0] kind, input logic [XLEN-1:0] value, input string name);
        exp_q.push_back(value);
        kind_q.push_back(kind);
        name_q.push_back(name);
    endtask

    // Scoreboard monitor: compare every pending expectation against what the DUT presents now.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            logic [XLEN-1:0] e;
            logic [XLEN-1:0] act;
            logic [1:0]      k;
            string           n;
            e = exp_q.pop_front();
            k = kind_q.pop_front();
            n = name_q.pop_front();
            case (k)
                K_RD0:   act = rd_data[0 +: XLEN];
                K_RD1:   act = rd_data[XLEN +: XLEN];
                K_RDY:   act = {{(XLEN-1){1'b0}}, ready};
                default: act = {{(XLEN-1){1'b0}}, wr_conflict};
            endcase
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h at %0t", n, act, e, $time);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach end of stimulus");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed stimulus
    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        tick();
        expect_val(K_RDY,  0, "reset_ready");
        expect_val(K_CONF, 0, "reset_conflict");
        expect_val(K_RD0,  0, "reset_rd0");
        tick();
        reset = 1'b0;
        // Attempt to write x5 throughout the clear; it must be ignored.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        for (int i = 1; i <= NREGS - 1; i++) begin
            tick();
            if (i == NREGS - 1) begin
                drive(0, 0, 0, 0, 0, 0, 5, 0);
                expect_val(K_RDY, 1, "clear_ready_rise");
                expect_val(K_RD0, 0, "clear_x5_zero_after_ready");
            end else if (i == NREGS - 2) begin
                expect_val(K_RDY, 0, "clear_ready_last_low");
                expect_val(K_RD0, 0, "clear_rd0_gated");
            end else if (i == 1) begin
                expect_val(K_RDY, 0, "clear_ready_low");
                expect_val(K_RD0, 0, "clear_rd0_first");
            end
        end

        // Basic write/read
        drive(1, 8, 32'h8FC8EC96, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 32'h294DA537, 0, 0, 0, 8, 0);
        expect_val(K_RD0, 32'h8FC8EC96, "basic_x8_early");
        tick();
        drive(0, 0, 0, 0, 0, 0, 8, 9);
        expect_val(K_RD0, 32'h8FC8EC96, "basic_x8");
        expect_val(K_RD1, 32'h294DA537, "basic_x9");
        tick();

        // x0 hardwiring, with both ports writing x0
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0);
        expect_val(K_RD0, 0, "x0_same_cycle_rd0");
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_val(K_RD0,  0, "x0_rd0");
        expect_val(K_RD1,  0, "x0_rd1");
        expect_val(K_CONF, 0, "x0_no_conflict");
        tick();

        // Dual-write collision on x12
        drive(1, 12, 32'h11111111, 1, 12, 32'h22222222, 0, 0);
        expect_val(K_CONF, 0, "collide_conflict_not_yet");
        tick();
        drive(0, 0, 0, 0, 0, 0, 12, 0);
        expect_val(K_CONF, 1, "collide_conflict_pulse");
        expect_val(K_RD0, 32'h22222222, "collide_port1_wins");
        tick();
        expect_val(K_CONF, 0, "collide_conflict_drop");
        tick();

        // Same-cycle read of a register being written
        drive(1, 3, 32'h00000003, 0, 0, 0, 0, 0);
        tick();
        drive(1, 3, 32'h9C5479CE, 0, 0, 0, 3, 0);
`ifdef REGFILE_BYPASS_EN
        expect_val(K_RD0, 32'h9C5479CE, "bypass_same_cycle");
`else
        expect_val(K_RD0, 32'h00000003, "nobypass_same_cycle");
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        expect_val(K_RD0, 32'h9C5479CE, "bypass_next_cycle");
        tick();

        // Mid-run reset
        drive(1, 20, 32'h00000020, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 20, 0);
        expect_val(K_RD0, 32'h00000020, "midrun_x20_written");
        tick();
        reset = 1'b1;
        expect_val(K_RDY, 1, "midrun_ready_before_edge");
        tick();
        reset = 1'b0;
        expect_val(K_RDY, 0, "midrun_ready_dropped");
        expect_val(K_RD0, 0, "midrun_rd0_gated");
        for (int i = 1; i <= NREGS - 1; i++) begin
            tick();
            if (i == NREGS - 2) begin
                expect_val(K_RDY, 0, "midrun_ready_last_low");
            end else if (i == NREGS - 1) begin
                expect_val(K_RDY, 1, "midrun_ready_rise");
                expect_val(K_RD0, 0, "midrun_x20_cleared");
            end
        end
        tick();
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
